picorv_mem_arbiter: RTL

Two-requester memory arbiter that shares the single unified instruction/data memory between the PicoRV32 core's native memory port and the vector coprocessor's load/store port (vlse/vsse element traffic). Sits between both masters and the memory model/SRAM. Each transaction is latched at grant and issued downstream as one registered request. Default policy is alternating round-robin; an optional vector burst mode is available.

---
 rtl/picorv_mem_pkg.sv | 23 ++
 rtl/picorv_rr_grant.sv | 71 +++++++
 rtl/picorv_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/picorv_mem_pkg.sv
// Shared types for the PicoRV32 / vector coprocessor memory arbiter.
// Optional vector burst mode is enabled with MEM_ARB_VEC_BURST_EN.
package picorv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_BUSY = 2'd1,
        ST_VEC_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VEC = 1'b1
    } gnt_id_e;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv_rr_grant.sv
// Grant decision for the arbiter: round-robin on ties, plus the vector
// burst allowance and its counter when MEM_ARB_VEC_BURST_EN is defined.
module picorv_rr_grant
    import picorv_mem_pkg::*;
(
`ifdef MEM_ARB_VEC_BURST_EN
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] burst_max_i,
    input  logic       vec_done_i,
`endif
    input  logic       idle_i,
    input  logic       cpu_valid_i,
    input  logic       vec_valid_i,
    input  gnt_id_e    last_grant_i,
    output logic [1:0] gnt_o
);

    logic vec_tie_win;

`ifdef MEM_ARB_VEC_BURST_EN
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       vec_done_q;

    // Vector keeps the bus only in the IDLE cycle right after its own
    // completion, and only while its allowance is not used up.
    assign vec_tie_win = (last_grant_i == GNT_CPU) ||
                         (vec_done_q && (burst_cnt_q < burst_max_i));

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (idle_i) begin
            if (gnt_o[GNT_CPU]) begin
                burst_cnt_d = '0;
            end else if (gnt_o[GNT_VEC]) begin
                if (cpu_valid_i && (burst_cnt_q != 4'hf)) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end else if (!vec_valid_i) begin
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= '0;
            vec_done_q  <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            vec_done_q  <= vec_done_i;
        end
    end
`else
    assign vec_tie_win = (last_grant_i == GNT_CPU);
`endif

    always_comb begin
        gnt_o = '0;
        if (idle_i) begin
            if (cpu_valid_i && vec_valid_i) begin
                gnt_o = vec_tie_win ? 2'b10 : 2'b01;
            end else if (cpu_valid_i) begin
                gnt_o = 2'b01;
            end else if (vec_valid_i) begin
                gnt_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Shares one memory port between the PicoRV32 core and the vector unit.
// Define MEM_ARB_VEC_BURST_EN to let the vector unit hold consecutive grants.
module picorv_mem_arbiter
    import picorv_mem_pkg::*;
#(
    parameter int VEC_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,

    input  logic        vec_mem_valid,
    input  logic [31:0] vec_mem_addr,
    input  logic [31:0] vec_mem_wdata,
    input  logic [3:0]  vec_mem_wstrb,
    output logic        vec_mem_ready,
    output logic [31:0] vec_mem_rdata,

    output logic        m_valid,
    output logic        m_instr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    arb_state_e state_q, state_d;
    gnt_id_e    last_grant_q, last_grant_d;
    logic       m_valid_q, m_valid_d;
    mem_req_t   req_q, req_d;
    logic [1:0] gnt;
    logic       idle;

    if (VEC_BURST_MAX < 1 || VEC_BURST_MAX > 15) begin : g_bad_burst_max
        $error("picorv_mem_arbiter: VEC_BURST_MAX must be 1..15");
    end

    assign idle = (state_q == ST_IDLE);

`ifdef MEM_ARB_VEC_BURST_EN
    localparam logic [3:0] BURST_MAX = 4'(VEC_BURST_MAX);
    logic vec_done;

    assign vec_done = (state_q == ST_VEC_BUSY) && m_ready;
`endif

    picorv_rr_grant u_grant (
`ifdef MEM_ARB_VEC_BURST_EN
        .clk          (clk),
        .reset        (reset),
        .burst_max_i  (BURST_MAX),
        .vec_done_i   (vec_done),
`endif
        .idle_i       (idle),
        .cpu_valid_i  (cpu_mem_valid),
        .vec_valid_i  (vec_mem_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_valid_d    = m_valid_q;
        req_d        = req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt[GNT_CPU]) begin
                    state_d      = ST_CPU_BUSY;
                    last_grant_d = GNT_CPU;
                    m_valid_d    = 1'b1;
                    req_d.instr  = cpu_mem_instr;
                    req_d.addr   = cpu_mem_addr;
                    req_d.wdata  = cpu_mem_wdata;
                    req_d.wstrb  = cpu_mem_wstrb;
                end else if (gnt[GNT_VEC]) begin
                    state_d      = ST_VEC_BUSY;
                    last_grant_d = GNT_VEC;
                    m_valid_d    = 1'b1;
                    req_d.instr  = 1'b0;
                    req_d.addr   = vec_mem_addr;
                    req_d.wdata  = vec_mem_wdata;
                    req_d.wstrb  = vec_mem_wstrb;
                end
            end
            ST_CPU_BUSY, ST_VEC_BUSY: begin
                if (m_ready) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_VEC;
            m_valid_q    <= 1'b0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            req_q        <= req_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_instr = req_q.instr;
    assign m_addr  = req_q.addr;
    assign m_wdata = req_q.wdata;
    assign m_wstrb = req_q.wstrb;

    assign cpu_mem_ready = m_ready && (state_q == ST_CPU_BUSY);
    assign vec_mem_ready = m_ready && (state_q == ST_VEC_BUSY);
    assign cpu_mem_rdata = m_rdata;
    assign vec_mem_rdata = m_rdata;

endmodule
